// File: rtl/stack_unwind_sequencer.sv
// rtl/stack_unwind_sequencer.sv - pops a RET (PC lo, PC hi) or RTI (FLAGS, PC lo, PC hi) frame
// and delivers the restored PC/flags as single-cycle load pulses.
module stack_unwind_sequencer #(
  parameter int DATA_W   = 16,
  parameter int PC_W     = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_ret,
  input  logic              start_rti,
  output logic              pop_req,
  input  logic              pop_gnt,
  input  logic [DATA_W-1:0] pop_data,
  input  logic              pop_data_valid,
  output logic              busy,
  output logic [PC_W-1:0]   pc_out,
  output logic              pc_load,
  output logic [DATA_W-1:0] flags_out,
  output logic              flags_load,
  output logic              err
);

  typedef enum logic [2:0] {
    IDLE, REQ_FLAG, WAIT_FLAG, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, COMMIT
  } state_t;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              is_rti;
  logic [DATA_W-1:0] flags_stage;
  logic [PC_W-1:0]   pc_stage;
  logic              timeout;

  assign timeout = (wait_cnt == 4'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      is_rti      <= 1'b0;
      flags_stage <= '0;
      pc_stage    <= '0;
      pop_req     <= 1'b0;
      busy        <= 1'b0;
      pc_out      <= '0;
      pc_load     <= 1'b0;
      flags_out   <= '0;
      flags_load  <= 1'b0;
      err         <= 1'b0;
    end else begin
      pc_load    <= 1'b0;
      flags_load <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          // RTI takes priority when both starts arrive together
          if (start_rti) begin
            state   <= REQ_FLAG;
            is_rti  <= 1'b1;
            busy    <= 1'b1;
            pop_req <= 1'b1;
          end else if (start_ret) begin
            state   <= REQ_LO;
            is_rti  <= 1'b0;
            busy    <= 1'b1;
            pop_req <= 1'b1;
          end
        end
        REQ_FLAG, REQ_LO, REQ_HI: begin
          if (pop_gnt) begin
            pop_req  <= 1'b0;
            wait_cnt <= '0;
            case (state)
              REQ_FLAG: state <= WAIT_FLAG;
              REQ_LO:   state <= WAIT_LO;
              default:  state <= WAIT_HI;
            endcase
          end
        end
        WAIT_FLAG, WAIT_LO, WAIT_HI: begin
          if (pop_data_valid) begin
            case (state)
              WAIT_FLAG: begin
                flags_stage <= pop_data;
                state       <= REQ_LO;
                pop_req     <= 1'b1;
              end
              WAIT_LO: begin
                pc_stage[DATA_W-1:0] <= pop_data;
                state                <= REQ_HI;
                pop_req              <= 1'b1;
              end
              default: begin
                pc_stage[PC_W-1:DATA_W] <= pop_data;
                pc_out     <= {pop_data, pc_stage[DATA_W-1:0]};
                pc_load    <= 1'b1;
                flags_load <= is_rti;
                if (is_rti) flags_out <= flags_stage;
                state      <= COMMIT;
              end
            endcase
          end else if (timeout) begin
            state <= IDLE;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        COMMIT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          pop_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_unwind_sequencer.sv
// tb/tb_stack_unwind_sequencer.sv - randomized bench for stack_unwind_sequencer against a
// stack-queue memory model; expected PC, flags, pop count and latency come from the frame rules.
module tb_stack_unwind_sequencer;

  logic        clk = 1'b0;
  logic        rst, start_ret, start_rti, pop_gnt, pop_data_valid;
  logic [15:0] pop_data;
  logic        pop_req, busy, pc_load, flags_load, err;
  logic [31:0] pc_out;
  logic [15:0] flags_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] stk[$];

  int          o_lat, o_flcyc, o_pops, o_req, o_loads, o_flloads, o_errs, o_explat;
  logic [31:0] o_pc;
  logic [15:0] o_fl;
  bit          o_busy1, o_done;

  always #5 clk = ~clk;

  stack_unwind_sequencer dut (
    .clk(clk), .rst(rst), .start_ret(start_ret), .start_rti(start_rti),
    .pop_req(pop_req), .pop_gnt(pop_gnt), .pop_data(pop_data), .pop_data_valid(pop_data_valid),
    .busy(busy), .pc_out(pc_out), .pc_load(pc_load), .flags_out(flags_out),
    .flags_load(flags_load), .err(err)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  // Drives one start and plays the memory stage: grant after g cycles, data after 1+v cycles.
  task automatic run_frame(input bit rti, input bit ret, input int glo, input int ghi,
                           input int vlo, input int vhi, input int mid_ret_at, input bit noise);
    int mst, gc, vc;
    mst = 0; gc = 0; vc = 0;
    o_lat = -1; o_flcyc = -1; o_pops = 0; o_req = 0; o_loads = 0; o_flloads = 0;
    o_errs = 0; o_explat = 1; o_pc = '0; o_fl = '0; o_busy1 = 0; o_done = 0;
    start_rti = rti; start_ret = ret;
    tick();
    start_rti = 0; start_ret = 0;
    for (int cyc = 1; cyc < 400; cyc++) begin
      pop_gnt = 0; pop_data_valid = 0; pop_data = 16'($urandom);
      start_ret = (cyc == mid_ret_at);
      if (cyc == 1) o_busy1 = busy;
      if (pop_req) o_req++;
      if (pc_load) begin o_loads++; o_lat = cyc; o_pc = pc_out; end
      if (flags_load) begin o_flloads++; o_flcyc = cyc; o_fl = flags_out; end
      if (err) o_errs++;
      if (cyc > 1 && !busy) begin o_done = 1; break; end
      if (noise && mst == 0 && !pop_req) pop_data_valid = 1'($urandom_range(1, 0));
      if (mst == 0 && pop_req) begin
        mst = 1; gc = int'($urandom_range(ghi, glo)); o_explat += gc;
      end
      if (mst == 1) begin
        if (gc == 0) begin
          pop_gnt = 1; mst = 2;
          vc = int'($urandom_range(vhi, vlo)); o_explat += vc + 2;
          if (noise) pop_data_valid = 1'($urandom_range(1, 0));
        end else gc--;
      end else if (mst == 2) begin
        if (vc == 0) begin
          pop_data_valid = 1;
          pop_data = (stk.size() > 0) ? stk.pop_back() : 16'hDEAD;
          o_pops++; mst = 0;
        end else vc--;
      end
      tick();
    end
    start_ret = 0; pop_gnt = 0; pop_data_valid = 0;
  endtask

  task automatic push_frame(input bit rti, input logic [15:0] hi, input logic [15:0] lo,
                            input logic [15:0] fl);
    stk.delete();
    stk.push_back(hi);
    stk.push_back(lo);
    if (rti) stk.push_back(fl);
  endtask

  task automatic test_reset();
    rst = 1; start_ret = 0; start_rti = 0; pop_gnt = 0; pop_data_valid = 0; pop_data = '0;
    tick(); tick();
    rst = 0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (pop_req !== 1'b0) begin n_bad++; $display("FAIL reset_pop_req got %b want 0", pop_req); end
    n_cmp++; if (pc_out !== 32'h0) begin n_bad++; $display("FAIL reset_pc_out got %h want 0", pc_out); end
    n_cmp++; if (flags_out !== 16'h0) begin n_bad++; $display("FAIL reset_flags_out got %h want 0", flags_out); end
    n_cmp++; if ({pc_load, flags_load, err} !== 3'b000) begin
      n_bad++; $display("FAIL reset_pulses got %b want 000", {pc_load, flags_load, err});
    end
  endtask

  task automatic test_ret_basic();
    push_frame(0, 16'h00AB, 16'h1234, 16'h0);
    run_frame(0, 1, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (!o_done) begin n_bad++; $display("FAIL ret_done got timeout want finish"); end
    n_cmp++; if (o_busy1 !== 1'b1) begin n_bad++; $display("FAIL ret_busy_rise got %b want 1", o_busy1); end
    n_cmp++; if (o_pc !== 32'h00AB1234 || o_loads != 1) begin
      n_bad++; $display("FAIL ret_pc got %h x%0d want 00ab1234 x1", o_pc, o_loads);
    end
    n_cmp++; if (o_flloads != 0) begin n_bad++; $display("FAIL ret_flags_load got %0d want 0", o_flloads); end
    n_cmp++; if (o_lat != 5) begin n_bad++; $display("FAIL ret_latency got %0d want 5", o_lat); end
  endtask

  task automatic test_rti_basic();
    push_frame(1, 16'h0001, 16'h4000, 16'h0005);
    run_frame(1, 0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (o_pc !== 32'h00014000) begin n_bad++; $display("FAIL rti_pc got %h want 00014000", o_pc); end
    n_cmp++; if (o_fl !== 16'h0005 || o_flloads != 1) begin
      n_bad++; $display("FAIL rti_flags got %h x%0d want 0005 x1", o_fl, o_flloads);
    end
    n_cmp++; if (o_flcyc != o_lat) begin n_bad++; $display("FAIL rti_same_cycle got %0d want %0d", o_flcyc, o_lat); end
    n_cmp++; if (o_lat != 7) begin n_bad++; $display("FAIL rti_latency got %0d want 7", o_lat); end
  endtask

  task automatic test_gnt_stall();
    push_frame(0, 16'hBEEF, 16'hCAFE, 16'h0);
    run_frame(0, 1, 3, 3, 0, 0, 0, 0);
    n_cmp++; if (o_req != 8) begin n_bad++; $display("FAIL stall_req_cycles got %0d want 8", o_req); end
    n_cmp++; if (o_pops != 2) begin n_bad++; $display("FAIL stall_pops got %0d want 2", o_pops); end
    n_cmp++; if (o_pc !== 32'hBEEFCAFE || o_lat != 11) begin
      n_bad++; $display("FAIL stall_result got %h@%0d want beefcafe@11", o_pc, o_lat);
    end
  endtask

  task automatic test_both_start();
    push_frame(1, 16'h7777, 16'h5555, 16'h00C3);
    run_frame(1, 1, 0, 1, 0, 1, 3, 0);
    n_cmp++; if (o_pops != 3) begin n_bad++; $display("FAIL both_pops got %0d want 3", o_pops); end
    n_cmp++; if (o_pc !== 32'h77775555 || o_fl !== 16'h00C3 || o_loads != 1 || o_flloads != 1) begin
      n_bad++; $display("FAIL both_result got %h/%h x%0d want 77775555/00c3 x1", o_pc, o_fl, o_loads);
    end
    n_cmp++; if (o_lat != o_explat) begin n_bad++; $display("FAIL both_latency got %0d want %0d", o_lat, o_explat); end
  endtask

  task automatic test_timeout();
    int err_cyc, err_cnt, loads;
    bit busy_at_err;
    err_cyc = -1; err_cnt = 0; loads = 0; busy_at_err = 1;
    start_ret = 1; tick(); start_ret = 0;
    pop_gnt = 1; tick(); pop_gnt = 0;
    for (int c = 2; c < 22; c++) begin
      if (err) begin err_cnt++; if (err_cyc < 0) begin err_cyc = c; busy_at_err = busy; end end
      if (pc_load) loads++;
      tick();
    end
    n_cmp++; if (err_cyc != 17 || err_cnt != 1) begin
      n_bad++; $display("FAIL timeout_err got cyc %0d x%0d want cyc 17 x1", err_cyc, err_cnt);
    end
    n_cmp++; if (loads != 0 || busy_at_err !== 1'b0 || pop_req !== 1'b0) begin
      n_bad++; $display("FAIL timeout_idle got loads %0d busy %b req %b want 0 0 0", loads, busy_at_err, pop_req);
    end
    push_frame(0, 16'h0102, 16'h0304, 16'h0);
    run_frame(0, 1, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (o_pc !== 32'h01020304 || o_errs != 0) begin
      n_bad++; $display("FAIL timeout_recover got %h err %0d want 01020304 err 0", o_pc, o_errs);
    end
    push_frame(0, 16'h0A0B, 16'h0C0D, 16'h0);
    run_frame(0, 1, 0, 0, 14, 14, 0, 0);
    n_cmp++; if (o_pc !== 32'h0A0B0C0D || o_errs != 0 || o_lat != 33) begin
      n_bad++; $display("FAIL wait_edge got %h err %0d lat %0d want 0a0b0c0d err 0 lat 33", o_pc, o_errs, o_lat);
    end
  endtask

  task automatic test_reset_mid();
    int bad_after;
    bad_after = 0;
    start_ret = 1; tick(); start_ret = 0;
    pop_gnt = 1; tick(); pop_gnt = 0;
    pop_data_valid = 1; pop_data = 16'h2222; tick(); pop_data_valid = 0;
    pop_gnt = 1; tick(); pop_gnt = 0;
    rst = 1; tick(); rst = 0;
    n_cmp++; if (busy !== 1'b0 || pc_load !== 1'b0 || pc_out !== 32'h0 || pop_req !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid got busy %b load %b pc %h req %b want 0 0 0 0", busy, pc_load, pc_out, pop_req);
    end
    pop_data_valid = 1; pop_data = 16'h0001; tick(); pop_data_valid = 0;
    repeat (3) begin
      if (busy !== 1'b0 || pc_load !== 1'b0 || err !== 1'b0) bad_after++;
      tick();
    end
    n_cmp++; if (bad_after != 0) begin n_bad++; $display("FAIL rst_late_valid got %0d active cycles want 0", bad_after); end
  endtask

  task automatic test_back_to_back();
    bit          rti, ret;
    logic [15:0] hi, lo, fl;
    for (int i = 0; i < 40; i++) begin
      rti = 1'($urandom_range(1, 0));
      ret = rti ? 1'($urandom_range(1, 0)) : 1'b1;
      hi = 16'($urandom); lo = 16'($urandom); fl = 16'($urandom);
      push_frame(rti, hi, lo, fl);
      run_frame(rti, ret, 0, 3, 0, 4, int'($urandom_range(6, 0)), 1);
      n_cmp++; if (!o_done || o_errs != 0 || o_loads != 1 || o_pc !== {hi, lo}) begin
        n_bad++; $display("FAIL rand%0d_pc got %h x%0d err %0d want %h x1", i, o_pc, o_loads, o_errs, {hi, lo});
      end
      n_cmp++; if (o_flloads != int'(rti) || (rti && (o_fl !== fl || o_flcyc != o_lat))) begin
        n_bad++; $display("FAIL rand%0d_flags got %h x%0d want %h x%0d", i, o_fl, o_flloads, fl, rti);
      end
      n_cmp++; if (o_lat != o_explat || o_pops != (rti ? 3 : 2) || stk.size() != 0) begin
        n_bad++; $display("FAIL rand%0d_seq got lat %0d pops %0d want lat %0d pops %0d", i, o_lat, o_pops, o_explat, rti ? 3 : 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ret_basic();
    test_rti_basic();
    test_gnt_stall();
    test_both_start();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
